// File: rtl/fnd_pkg.sv
// Shared FND display definitions: BCD nibble width, powers of ten,
// the conversion FSM states and 7-segment digit codes.
package fnd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fnd_state_t;

    // Segment order {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_CODE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/fnd_bcd_add3.sv
// One BCD nibble correction step of the shift-add-3 conversion.
import fnd_pkg::*;

module fnd_bcd_add3 (
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/fnd_bcd_value.sv
// Sequential binary-to-BCD converter feeding the FND scan driver.
// Leading-zero blanking is built only when FND_LZ_BLANK_EN is defined.
import fnd_pkg::*;

module fnd_bcd_value #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [BIN_W-1:0]          i_value,
    input  logic                      i_load,
    output logic                      o_busy,
    output logic                      o_valid,
    output logic [BCD_W*N_DIGITS-1:0] o_digits,
    output logic                      o_overflow,
    output logic [N_DIGITS-1:0]       o_blank
);

    localparam int DW    = BCD_W * N_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0]      LIMIT = pow10(N_DIGITS);
    localparam logic [BIN_W-1:0] MAX_V = BIN_W'(LIMIT - 64'd1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIN_W - 1);

    fnd_state_t state_q, state_nx;

    logic [BIN_W-1:0]    bin_q;
    logic [DW-1:0]       bcd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic [BIN_W-1:0]    pend_q;
    logic                pend_ovf_q;
    logic                pend_vld_q;

    logic                in_ovf;
    logic [BIN_W-1:0]    in_val;
    logic [DW-1:0]       bcd_adj;
    logic [DW-1:0]       bcd_sh;
    logic [N_DIGITS-1:0] blank_c;

    // Clamp at capture so the scratch BCD register can never overflow.
    assign in_ovf = 64'(i_value) >= LIMIT;
    assign in_val = in_ovf ? MAX_V : i_value;

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_add3
        fnd_bcd_add3 u_add3 (
            .d (bcd_q[k*BCD_W +: BCD_W]),
            .q (bcd_adj[k*BCD_W +: BCD_W])
        );
    end

    assign bcd_sh = {bcd_adj[DW-2:0], bin_q[BIN_W-1]};

`ifdef FND_LZ_BLANK_EN
    logic lead;
    always_comb begin
        blank_c = '0;
        lead    = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            if (bcd_q[k*BCD_W +: BCD_W] != '0) lead = 1'b0;
            blank_c[k] = lead;
        end
    end
`else
    assign blank_c = '0;
`endif

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            IDLE:    if (i_load) state_nx = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_nx = DONE;
            DONE:    state_nx = (pend_vld_q || i_load) ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign o_busy = (state_q != IDLE) || pend_vld_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            pend_q     <= '0;
            pend_ovf_q <= 1'b0;
            pend_vld_q <= 1'b0;
            o_valid    <= 1'b0;
            o_digits   <= '0;
            o_overflow <= 1'b0;
            o_blank    <= '0;
        end else begin
            state_q <= state_nx;
            o_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_load) begin
                        bin_q <= in_val;
                        ovf_q <= in_ovf;
                        bcd_q <= '0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_q << 1;
                    bcd_q <= bcd_sh;
                    cnt_q <= cnt_q + 1'b1;
                    if (i_load) begin
                        pend_q     <= in_val;
                        pend_ovf_q <= in_ovf;
                        pend_vld_q <= 1'b1;
                    end
                end
                DONE: begin
                    o_valid    <= 1'b1;
                    o_digits   <= bcd_q;
                    o_overflow <= ovf_q;
                    o_blank    <= blank_c;
                    bcd_q      <= '0;
                    cnt_q      <= '0;
                    // A queued request starts first; a fresh load then queues.
                    if (pend_vld_q) begin
                        bin_q      <= pend_q;
                        ovf_q      <= pend_ovf_q;
                        pend_vld_q <= i_load;
                        if (i_load) begin
                            pend_q     <= in_val;
                            pend_ovf_q <= in_ovf;
                        end
                    end else if (i_load) begin
                        bin_q <= in_val;
                        ovf_q <= in_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fnd_bcd_value.sv
// Randomised self-checking bench for fnd_bcd_value (4 digits, 14-bit input).
module tb_fnd_bcd_value;

    localparam int N     = 4;
    localparam int BIN_W = 14;
    localparam int LAT   = BIN_W + 1;

    logic             clk;
    logic             rst_n;
    logic [BIN_W-1:0] value;
    logic             load;
    logic             busy;
    logic             valid;
    logic [4*N-1:0]   digits;
    logic             overflow;
    logic [N-1:0]     blank;

    int checks = 0;
    int errors = 0;

    fnd_bcd_value #(.N_DIGITS(N), .BIN_W(BIN_W)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_value    (value),
        .i_load     (load),
        .o_busy     (busy),
        .o_valid    (valid),
        .o_digits   (digits),
        .o_overflow (overflow),
        .o_blank    (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_clamp(input int v);
        return (v >= 10 ** N) ? 10 ** N - 1 : v;
    endfunction

    function automatic logic [4*N-1:0] m_digits(input int v);
        logic [4*N-1:0] d;
        int c;
        c = m_clamp(v);
        d = '0;
        for (int k = 0; k < N; k++) begin
            d[4*k +: 4] = 4'((c / (10 ** k)) % 10);
        end
        return d;
    endfunction

    function automatic logic [N-1:0] m_blank(input int v);
        logic [N-1:0] b;
        b = '0;
`ifdef FND_LZ_BLANK_EN
        for (int k = 1; k < N; k++) begin
            if (m_clamp(v) < 10 ** k) b[k] = 1'b1;
        end
`endif
        return b;
    endfunction

    task automatic convert(input int v, output int lat,
                           output logic [4*N-1:0] d, output logic ovf,
                           output logic [N-1:0] b, output logic vnext);
        @(negedge clk);
        value = BIN_W'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        lat   = -1;
        d     = 'x;
        ovf   = 1'bx;
        b     = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = n;
                d   = digits;
                ovf = overflow;
                b   = blank;
                break;
            end
        end
        @(posedge clk);
        #1;
        vnext = valid;
    endtask

    task automatic check_conv(input string name, input int v);
        int lat;
        logic [4*N-1:0] d;
        logic ovf, vn;
        logic [N-1:0] b;
        convert(v, lat, d, ovf, b, vn);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL %s latency v=%0d got %0d want %0d", name, v, lat, LAT);
        end
        checks++;
        if (d !== m_digits(v)) begin
            errors++;
            $display("FAIL %s digits v=%0d got %h want %h", name, v, d, m_digits(v));
        end
        checks++;
        if (ovf !== (v >= 10 ** N)) begin
            errors++;
            $display("FAIL %s overflow v=%0d got %b want %b", name, v, ovf, v >= 10 ** N);
        end
        checks++;
        if (b !== m_blank(v)) begin
            errors++;
            $display("FAIL %s blank v=%0d got %b want %b", name, v, b, m_blank(v));
        end
        checks++;
        if (vn !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_pulse v=%0d got %b want 0", name, v, vn);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (digits !== m_digits(v)) begin
            errors++;
            $display("FAIL %s hold v=%0d got %h want %h", name, v, digits, m_digits(v));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({digits, valid, busy, overflow, blank} !== '0) begin
            errors++;
            $display("FAIL reset got d=%h v=%b b=%b o=%b bl=%b want all 0",
                     digits, valid, busy, overflow, blank);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        check_conv("basic_1234", 1234);
        check_conv("basic_fan5", 5);
    endtask

    task automatic test_overflow();
        check_conv("ovf_12000", 12000);
        check_conv("ovf_zero", 0);
        check_conv("ovf_10000", 10000);
        check_conv("ovf_9999", 9999);
    endtask

    task automatic test_blank();
        check_conv("blank_5", 5);
        check_conv("blank_0", 0);
        check_conv("blank_1030", 1030);
        check_conv("blank_90", 90);
    endtask

    task automatic test_back_to_back();
        int got;
        int at [2];
        logic [4*N-1:0] dv [2];
        logic busy_bad;
        got = 0;
        busy_bad = 1'b0;
        @(negedge clk);
        value = BIN_W'(5);
        load  = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            load  = (n == 4) || (n == 7);
            value = BIN_W'((n == 4) ? 42 : 77);
            @(posedge clk);
            #1;
            if (valid) begin
                if (got < 2) begin
                    at[got] = n;
                    dv[got] = digits;
                end
                got++;
            end else if (got < 2 && !busy) begin
                busy_bad = 1'b1;
            end
        end
        load = 1'b0;
        checks++;
        if (got !== 2) begin
            errors++;
            $display("FAIL b2b pulses got %0d want 2", got);
        end
        if (got >= 2) begin
            checks++;
            if (dv[0] !== m_digits(5) || dv[1] !== m_digits(77)) begin
                errors++;
                $display("FAIL b2b values got %h,%h want %h,%h",
                         dv[0], dv[1], m_digits(5), m_digits(77));
            end
            checks++;
            if (at[0] !== LAT || at[1] !== 2 * LAT) begin
                errors++;
                $display("FAIL b2b timing got %0d,%0d want %0d,%0d",
                         at[0], at[1], LAT, 2 * LAT);
            end
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL b2b busy got 0 before second result want 1");
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b busy_end got %b want 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        logic seen;
        logic busy_bad;
        seen = 1'b0;
        busy_bad = 1'b0;
        @(negedge clk);
        value = BIN_W'(9999);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({digits, valid, busy, overflow, blank} !== '0) begin
            errors++;
            $display("FAIL abort_reset got d=%h v=%b b=%b o=%b bl=%b want all 0",
                     digits, valid, busy, overflow, blank);
        end
        @(negedge clk);
        value = BIN_W'(77);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (valid) seen = 1'b1;
            if (busy) busy_bad = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_valid got pulse want none");
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL abort_busy got 1 want 0");
        end
    endtask

    task automatic test_random();
        int edge_vals [4] = '{9999, 10000, 0, 16383};
        int v;
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 4) v = edge_vals[(i / 5) % 4];
            else v = int'($urandom_range(0, 16383));
            check_conv("random", v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_blank();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
